// File: rtl/sik_instr_encoder.sv
// ============================================================================
// Module   : sik_instr_encoder
// Purpose  : Turns symbolic SIK instructions into 16-bit words plus interleaved
//            per-thread instruction-memory addresses, adding a prefix word when needed.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sik_instr_encoder #(
  parameter int          ADDR_W  = 16,
  parameter int unsigned T0_BASE = 0,
  parameter int unsigned T1_BASE = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_ext,
  input  logic [3:0]        in_op,
  input  logic [15:0]       in_imm,
  input  logic              in_thread,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       out_word,
  output logic [ADDR_W-1:0] out_addr,
  output logic [ADDR_W-1:0] words_emitted,
  output logic              err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PRE  = 2'd1;
  localparam logic [1:0] S_MAIN = 2'd2;

  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] CNT_ONE   = ADDR_W'(1);

  logic [1:0]        state, state_nxt;
  logic              accept, legal, need_pre, fire;
  logic [15:0]       main_word, pre_word, main_q;
  logic              thread_q;
  logic [ADDR_W-1:0] cnt0, cnt1;

  always_comb begin
    legal     = in_ext ? (in_op inside {[4'd1:4'd12]}) : (in_op inside {[4'd1:4'd8]});
    need_pre  = !in_ext && (in_imm[15:12] != 4'h0);
    main_word = in_ext ? {12'h000, in_op} : {in_op, in_imm[11:0]};
    pre_word  = {4'hF, 8'h00, in_imm[15:12]};
    accept    = in_valid && in_ready;
    fire      = (state != S_IDLE) && out_ready;
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept && legal) state_nxt = need_pre ? S_PRE : S_MAIN;
      S_PRE:   if (out_ready) state_nxt = S_MAIN;
      S_MAIN:  if (out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == S_IDLE);
    out_valid = (state != S_IDLE);
  end

  // Accept (IDLE only) and fire (PRE/MAIN only) are mutually exclusive.
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_word      <= 16'h0000;
      out_addr      <= '0;
      main_q        <= 16'h0000;
      thread_q      <= 1'b0;
      cnt0          <= ADDR_W'(T0_BASE);
      cnt1          <= ADDR_W'(T1_BASE);
      words_emitted <= '0;
      err           <= 1'b0;
    end else begin
      if (accept) begin
        if (!legal) begin
          err <= 1'b1;
        end else begin
          thread_q <= in_thread;
          main_q   <= main_word;
          out_word <= need_pre ? pre_word : main_word;
          out_addr <= in_thread ? cnt1 : cnt0;
        end
      end
      if (fire) begin
        words_emitted <= words_emitted + CNT_ONE;
        if (thread_q) cnt1 <= cnt1 + ADDR_STEP;
        else          cnt0 <= cnt0 + ADDR_STEP;
        if (state == S_PRE) begin
          out_word <= main_q;
          out_addr <= out_addr + ADDR_STEP;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sik_instr_encoder.sv
// ============================================================================
// Module   : tb_sik_instr_encoder
// Purpose  : Self-checking bench: queue-based reference model plus directed scenarios.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sik_instr_encoder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_ext = 1'b0;
  logic [3:0]  in_op = 4'h0;
  logic [15:0] in_imm = 16'h0000;
  logic        in_thread = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_word;
  logic [15:0] out_addr;
  logic [15:0] words_emitted;
  logic        err;

  sik_instr_encoder #(.ADDR_W(16), .T0_BASE(0), .T1_BASE(1)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ext(in_ext), .in_op(in_op), .in_imm(in_imm), .in_thread(in_thread),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_word(out_word), .out_addr(out_addr),
    .words_emitted(words_emitted), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: words still owed to the consumer, in emission order.
  typedef struct {
    logic [15:0] w;
    logic [15:0] a;
  } ent_t;

  ent_t        mq[$];
  logic [15:0] m_cnt[2];
  logic        m_err;
  logic [15:0] m_words;
  bit          started = 0;

  always @(posedge clk) begin
    if (!reset) begin
      mq.delete();
      m_cnt[0] = 16'd0;
      m_cnt[1] = 16'd1;
      m_err    = 1'b0;
      m_words  = 16'd0;
      started  = 1;
    end else if (started) begin
      if (mq.size() == 0 && in_valid) begin
        bit ok;
        ok = in_ext ? (in_op >= 4'd1 && in_op <= 4'd12) : (in_op >= 4'd1 && in_op <= 4'd8);
        if (!ok) begin
          m_err = 1'b1;
        end else if (!in_ext && in_imm[15:12] != 4'h0) begin
          mq.push_back('{w: {4'hF, 8'h00, in_imm[15:12]}, a: m_cnt[in_thread]});
          mq.push_back('{w: {in_op, in_imm[11:0]}, a: m_cnt[in_thread] + 16'd2});
          m_cnt[in_thread] = m_cnt[in_thread] + 16'd4;
        end else begin
          mq.push_back('{w: in_ext ? {12'h000, in_op} : {in_op, in_imm[11:0]}, a: m_cnt[in_thread]});
          m_cnt[in_thread] = m_cnt[in_thread] + 16'd2;
        end
      end else if (mq.size() != 0 && out_ready) begin
        void'(mq.pop_front());
        m_words = m_words + 16'd1;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("in_ready", {31'd0, in_ready}, {31'd0, mq.size() == 0});
      chk("out_valid", {31'd0, out_valid}, {31'd0, mq.size() != 0});
      chk("err", {31'd0, err}, {31'd0, m_err});
      chk("words_emitted", {16'd0, words_emitted}, {16'd0, m_words});
      if (mq.size() != 0) begin
        chk("out_word", {16'd0, out_word}, {16'd0, mq[0].w});
        chk("out_addr", {16'd0, out_addr}, {16'd0, mq[0].a});
      end
    end
  end

  // Log of every completed output handshake, for the literal checks.
  logic [31:0] log_q[$];
  always @(posedge clk) begin
    if (reset && out_valid && out_ready) log_q.push_back({out_word, out_addr});
  end

  function automatic logic [31:0] log_at(input int i);
    if (i < log_q.size()) return log_q[i];
    return 32'hDEAD_DEAD;
  endfunction

  task automatic send(input logic ext, input logic [3:0] op, input logic [15:0] imm, input logic thr);
    bit done = 0;
    in_ext = ext; in_op = op; in_imm = imm; in_thread = thr; in_valid = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      if (in_ready) begin
        @(posedge clk);
        done = 1;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (!done) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      if (in_ready && !out_valid) done = 1;
      else @(negedge clk);
    end
    if (!done) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_word", {16'd0, out_word}, 32'd0);
    chk("rst_out_addr", {16'd0, out_addr}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // single-word push
    send(1'b0, 4'd8, 16'h0123, 1'b0);
    wait_idle();
    chk("t1_word", log_at(0), {16'h8123, 16'h0000});
    chk("t1_cnt", {16'd0, words_emitted}, 32'd1);

    // prefixed push
    send(1'b0, 4'd8, 16'hABCD, 1'b0);
    wait_idle();
    chk("t2_pre", log_at(1), {16'hF00A, 16'h0002});
    chk("t2_main", log_at(2), {16'h8BCD, 16'h0004});
    chk("t2_cnt", {16'd0, words_emitted}, 32'd3);

    // extended ops on thread 1
    send(1'b1, 4'd1, 16'hFFFF, 1'b1);
    send(1'b1, 4'd8, 16'h1234, 1'b1);
    wait_idle();
    chk("t3_add", log_at(3), {16'h0001, 16'h0001});
    chk("t3_ret", log_at(4), {16'h0008, 16'h0003});

    // backpressure in PRE; thread 0 continues at 6
    out_ready = 1'b0;
    send(1'b0, 4'd6, 16'h1005, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("bp_word", {16'd0, out_word}, 32'h0000_F001);
      chk("bp_addr", {16'd0, out_addr}, 32'd6);
      chk("bp_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_cnt", {16'd0, words_emitted}, 32'd5);
      @(negedge clk);
    end
    out_ready = 1'b1;
    wait_idle();
    chk("t4_pre", log_at(5), {16'hF001, 16'h0006});
    chk("t4_main", log_at(6), {16'h6005, 16'h0008});

    // illegal request
    send(1'b0, 4'hA, 16'h0001, 1'b0);
    chk("ill_err", {31'd0, err}, 32'd1);
    chk("ill_valid", {31'd0, out_valid}, 32'd0);
    chk("ill_ready", {31'd0, in_ready}, 32'd1);
    send(1'b0, 4'd8, 16'h0042, 1'b1);
    wait_idle();
    chk("t5_push", log_at(7), {16'h8042, 16'h0005});

    // reset while in PRE
    out_ready = 1'b0;
    send(1'b0, 4'd8, 16'h2001, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    chk("rp_valid", {31'd0, out_valid}, 32'd0);
    chk("rp_err", {31'd0, err}, 32'd0);
    chk("rp_cnt", {16'd0, words_emitted}, 32'd0);
    reset = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    send(1'b0, 4'd8, 16'h0007, 1'b0);
    send(1'b1, 4'd2, 16'h0000, 1'b1);
    wait_idle();
    chk("t6_t0", log_at(8), {16'h8007, 16'h0000});
    chk("t6_t1", log_at(9), {16'h0002, 16'h0001});

    // randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      reset     = ($urandom_range(0, 99) != 0);
      in_valid  = $urandom_range(0, 1);
      in_ext    = $urandom_range(0, 1);
      in_op     = 4'($urandom_range(0, 15));
      in_imm    = ($urandom_range(0, 1) != 0) ? 16'($urandom) : {4'h0, 12'($urandom)};
      in_thread = $urandom_range(0, 1);
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
    end
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_idle();
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sik_instr_encoder.md
Name: sik_instr_encoder

Overview:
- Encoding counterpart of the SIK instruction decoder.
- Accepts symbolic instructions (opcode class, opcode, 16-bit immediate, thread id) over a valid/ready handshake.
- Emits 16-bit SIK instruction words, each paired with its target instruction-memory address.
- Automatically emits a `pre` prefix word when an immediate does not fit in 12 bits.
- Addresses are generated per thread in the interleaved layout used by the fetch stage:
  - thread 0 at even addresses: 0, 2, 4, …
  - thread 1 at odd addresses: 1, 3, 5, …
- Feeds the memory loader or program-build path.

Parameters:
- ADDR_W, 16, width of the instruction-memory address and of the emitted-word counter.
- T0_BASE, 0, first address for thread 0.
- T1_BASE, 1, first address for thread 1.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- in_valid  in  1  instruction request valid.
- in_ready  out  1  encoder can accept a request.
- in_ext  in  1  1 = extended/no-arg op (encoded with [15:12]=0); 0 = normal op.
- in_op  in  4  opcode: the normal-op code, or the extended code placed in [3:0].
- in_imm  in  16  immediate; ignored when in_ext=1.
- in_thread  in  1  target thread (0/1).
- out_valid  out  1  out_word/out_addr valid.
- out_ready  in  1  consumer accepts the word.
- out_word  out  16  encoded instruction word.
- out_addr  out  ADDR_W  memory address for out_word.
- words_emitted  out  ADDR_W  count of output handshakes since reset.
- err  out  1  sticky flag: an illegal request was seen.

Behaviour:
- Reset (reset=0 at a clk edge):
  - state=IDLE; out_valid=0, out_word=0, out_addr=0, words_emitted=0, err=0.
  - Thread address counters set to T0_BASE/T1_BASE.
  - Any pending word is discarded, including mid-PRE or mid-MAIN.
  - in_ready=1 from the first cycle after reset deasserts.
- in_ready = (state==IDLE). Handshakes occur only when valid && ready are both high at a clk edge.
- Legal normal opcodes (in_ext=0): get 1, pop 2, put 3, call 4, jumpf 5, jump 6, jumpt 7, push 8.
- Legal extended opcodes (in_ext=1): 1..C (add, lt, sub, and, or, xor, dup, ret, sys, load, store, test).
- Encoding:
  - normal → {in_op, in_imm[11:0]}.
  - extended → {4'h0, 8'h00, in_op}.
  - pre → {4'hF, 8'h00, in_imm[15:12]}.
- A pre word is needed iff in_ext=0 && in_imm[15:12]!=0.
- State machine:
  - IDLE: on an accepted legal request, latch the fields. Go to PRE (out_word=pre word) if a pre is needed, else to MAIN (out_word=main word). out_valid=1 on the next cycle (latency 1).
  - IDLE, illegal request (normal op 0 or 9..F; extended op 0 or D..F): the request is still accepted (handshake completes), err<=1, no word is emitted, state stays IDLE.
  - PRE: hold out_word/out_addr stable while out_ready=0. On out_ready=1: increment that thread's address by 2 and words_emitted by 1, load the main word, go to MAIN.
  - MAIN: hold while out_ready=0. On out_ready=1: thread address +=2, words_emitted +=1, out_valid<=0, go to IDLE.
- Throughput:
  - Minimum 2 cycles per single-word instruction and 3 cycles per prefixed instruction.
  - No bypass from MAIN straight to a new accept.
- Address counters:
  - out_addr = current counter of the latched thread.
  - Counters wrap modulo 2^ADDR_W, so thread-1 parity is preserved.
  - Only the latched thread's counter changes.
- words_emitted wraps modulo 2^ADDR_W.
- err stays high until reset.
- in_valid high while in PRE/MAIN has no effect; the request waits for in_ready.
- Output word, address and valid are registered; no combinational path from in_* to out_*.

Test Plan:
- Reset, then push in_imm=0x0123, thread 0, out_ready=1 → one word 0x8123 at addr 0x0000; words_emitted=1; in_ready back to 1 the cycle after the handshake.
- push in_imm=0xABCD, thread 0, after the first test → 0xF00A at addr 2, then 0x8BCD at addr 4; words_emitted=3.
- extended add (op 1), thread 1, then extended ret (op 8), thread 1 → 0x0001 at addr 1, then 0x0008 at addr 3; the thread-0 counter is unchanged.
- Backpressure: out_ready=0 for 5 cycles during PRE of jump imm 0x1005 → out_word stays 0xF001, in_ready=0, counters frozen; on release, 0xF001 then 0x6005 are emitted.
- Illegal normal op 0xA with in_valid=1 → err=1 next cycle, out_valid stays 0, in_ready=1, addresses unchanged; a subsequent legal push still encodes correctly.
- Assert reset in PRE state → next cycle out_valid=0, err=0, words_emitted=0; the next thread-0 word goes to addr 0 and the next thread-1 word to addr 1.
